// File: rtl/uart_tx_arbiter_if.sv
// Requester, transmitter and status signals of uart_tx_arbiter, bundled as one port.
// The arbiter connects through the slave modport. Requesters and the transmitter use master.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int BYTES   = 4
);
    localparam int W  = 8 * BYTES;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*W-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_start;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 busy;
    logic [GW-1:0]        grant_id;

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, busy, grant_id
    );

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one async_transmitter between NUM_REQ word sources.
// It sends an optional tag byte, then the granted word MSB-first, using the TxD_start/TxD_busy handshake.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int BYTES   = 4,
    parameter int TAG_EN  = 1
) (
    input logic          clk,
    input logic          rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int W  = 8 * BYTES;
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NB = BYTES + ((TAG_EN != 0) ? 1 : 0);
    localparam int CW = $clog2(NB + 1);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(NB);
    localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t             state, state_n;
    logic [GW-1:0]      last, last_n;
    logic [GW-1:0]      gid, gid_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [W-1:0]       shift, shift_n;
    logic [NUM_REQ-1:0] ready, ready_n;
    logic               start, start_n;
    logic [7:0]         data, data_n;
    logic               busy_r, busy_n;

    logic               pick_found;
    logic [GW-1:0]      pick_idx;
    logic               tag_pending;
    logic [7:0]         tag_byte;

    // Two passes give round-robin order: first look above the last winner, then wrap from 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && (GW'(i) > last) && bus.req_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!pick_found && bus.req_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = GW'(i);
            end
        end
    end

    // The counter is still at its load value only while the tag byte is pending.
    assign tag_pending = (TAG_EN != 0) && (cnt == CNT_LOAD);
    assign tag_byte    = 8'hA0 | 8'(gid);

    always_comb begin
        state_n = state;
        last_n  = last;
        gid_n   = gid;
        cnt_n   = cnt;
        shift_n = shift;
        ready_n = '0;
        start_n = 1'b0;
        data_n  = data;
        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    gid_n   = pick_idx;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (bus.req_valid[gid]) begin
                    ready_n[gid] = 1'b1;
                    shift_n      = bus.req_data[gid*W +: W];
                    last_n       = gid;
                    cnt_n        = CNT_LOAD;
                    state_n      = START;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                if (!bus.tx_busy) begin
                    start_n = 1'b1;
                    data_n  = tag_pending ? tag_byte : shift[W-1 -: 8];
                    state_n = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    cnt_n = cnt - 1'b1;
                    if (!tag_pending) begin
                        shift_n = shift << 8;
                    end
                    state_n = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_n = (cnt != '0) ? START : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= LAST_INIT;
            gid    <= '0;
            cnt    <= '0;
            shift  <= '0;
            ready  <= '0;
            start  <= 1'b0;
            data   <= '0;
            busy_r <= 1'b0;
        end else begin
            state  <= state_n;
            last   <= last_n;
            gid    <= gid_n;
            cnt    <= cnt_n;
            shift  <= shift_n;
            ready  <= ready_n;
            start  <= start_n;
            data   <= data_n;
            busy_r <= busy_n;
        end
    end

    assign bus.req_ready = ready;
    assign bus.tx_start  = start;
    assign bus.tx_data   = data;
    assign bus.busy      = busy_r;
    assign bus.grant_id  = gid;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 4-byte tagged instance and a 2-byte untagged instance.
// Each instance drives a transmitter model that stays busy for 20 cycles per byte.
module tb_uart_tx_arbiter;
    localparam int BUSY_CYC = 20;

    logic clk = 1'b0;
    logic rst;
    logic ext_busy;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(2), .BYTES(4)) if1 ();
    uart_tx_arbiter_if #(.NUM_REQ(2), .BYTES(2)) if2 ();

    uart_tx_arbiter #(.NUM_REQ(2), .BYTES(4), .TAG_EN(1)) dut (
        .clk(clk), .rst(rst), .bus(if1.slave)
    );
    uart_tx_arbiter #(.NUM_REQ(2), .BYTES(2), .TAG_EN(0)) dut2 (
        .clk(clk), .rst(rst), .bus(if2.slave)
    );

    // The transmitter models ignore rst, so a byte already accepted completes.
    int tcnt1 = 0;
    int tcnt2 = 0;
    always @(posedge clk) begin
        if (tcnt1 != 0) tcnt1 <= tcnt1 - 1;
        else if (if1.tx_start) tcnt1 <= BUSY_CYC;
        if (tcnt2 != 0) tcnt2 <= tcnt2 - 1;
        else if (if2.tx_start) tcnt2 <= BUSY_CYC;
    end
    assign if1.tx_busy = (tcnt1 != 0) || ext_busy;
    assign if2.tx_busy = (tcnt2 != 0);

    // Counts every tx_start that is high while tx_busy is high, or high on two consecutive cycles.
    int   viol  = 0;
    logic prev1 = 1'b0;
    logic prev2 = 1'b0;
    always @(negedge clk) begin
        if (if1.tx_start && (if1.tx_busy || prev1)) viol <= viol + 1;
        if (if2.tx_start && (if2.tx_busy || prev2)) viol <= viol + 1;
        prev1 <= if1.tx_start;
        prev2 <= if2.tx_start;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [7:0] sent[$];
    int rdy_cnt[2];
    int first_ready, first_start, first_low, last_fall, fall_gap;

    // Steps whole cycles on dut. It drops each valid when its ready pulse appears.
    // It logs the bytes sent and returns once no request is pending and busy is low.
    task automatic wait_idle(input int max_cyc);
        int   cyc;
        logic done, prev_tb, prev_b;
        cyc = 0; done = 1'b0;
        prev_tb = if1.tx_busy; prev_b = if1.busy;
        sent.delete();
        rdy_cnt[0] = 0; rdy_cnt[1] = 0;
        first_ready = -1; first_start = -1; first_low = -1; last_fall = -1; fall_gap = -1;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (if1.req_ready[i]) begin
                    rdy_cnt[i]++;
                    if1.req_valid[i] = 1'b0;
                    if (first_ready < 0) first_ready = cyc;
                end
            end
            if (if1.tx_start) begin
                sent.push_back(if1.tx_data);
                if (first_start < 0) first_start = cyc;
            end
            if (!if1.tx_busy && first_low < 0) first_low = cyc;
            if (prev_tb && !if1.tx_busy) last_fall = cyc;
            if (prev_b && !if1.busy) fall_gap = cyc - last_fall;
            prev_tb = if1.tx_busy;
            prev_b  = if1.busy;
            if (cyc >= 2 && if1.req_valid == '0 && !if1.busy) done = 1'b1;
        end
        check("idle_reached", done, 1);
    endtask

    task automatic check_word(input string tag, input int off, input logic [7:0] tagb,
                              input logic [31:0] word);
        logic [7:0] got, exp;
        for (int k = 0; k < 5; k++) begin
            exp = (k == 0) ? tagb : word[31-8*(k-1) -: 8];
            got = (off + k < sent.size()) ? sent[off+k] : 8'hxx;
            check($sformatf("%s_b%0d", tag, k), got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen, hit;
        int   nstart;
        rst = 1'b1;
        ext_busy = 1'b0;
        if2.req_valid = '0;
        if2.req_data  = '0;
        if1.req_data  = {32'h55667788, 32'h11223344};
        if1.req_valid = 2'b11;
        repeat (3) @(negedge clk);
        check("rst_ready", if1.req_ready, 0);
        check("rst_start", if1.tx_start, 0);
        check("rst_busy", if1.busy, 0);
        check("rst_data", if1.tx_data, 0);
        check("rst_gid", if1.grant_id, 0);
        check("rst_busy2", if2.busy, 0);

        // Contention from reset: requester 0 first, then requester 1.
        rst = 1'b0;
        wait_idle(600);
        check("cont_len", sent.size(), 10);
        check("cont_rdy0", rdy_cnt[0], 1);
        check("cont_rdy1", rdy_cnt[1], 1);
        check_word("cont_w0", 0, 8'hA0, 32'h11223344);
        check_word("cont_w1", 5, 8'hA1, 32'h55667788);

        @(negedge clk);
        if1.req_valid = 2'b11;
        wait_idle(600);
        check("rot_len", sent.size(), 10);
        check_word("rot_w0", 0, 8'hA0, 32'h11223344);
        check_word("rot_w1", 5, 8'hA1, 32'h55667788);

        // Requester 1 withdraws before GRANT: no accept, and the pointer does not move.
        @(negedge clk);
        if1.req_valid = 2'b10;
        @(negedge clk);
        if1.req_valid = 2'b00;
        check("wd_grant_busy", if1.busy, 1);
        check("wd_grant_id", if1.grant_id, 1);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | (|if1.req_ready) | if1.tx_start;
        end
        check("wd_no_accept", seen, 0);
        check("wd_idle", if1.busy, 0);
        if1.req_valid = 2'b11;
        wait_idle(600);
        check("wd_next_len", sent.size(), 10);
        check_word("wd_next_w0", 0, 8'hA0, 32'h11223344);

        // Single word: latency, byte order and release of busy.
        @(negedge clk);
        if1.req_data[31:0] = 32'hDEADBEEF;
        if1.req_valid = 2'b01;
        wait_idle(300);
        check("sw_len", sent.size(), 5);
        check_word("sw_w", 0, 8'hA0, 32'hDEADBEEF);
        check("sw_rdy0", rdy_cnt[0], 1);
        check("sw_rdy1", rdy_cnt[1], 0);
        check("sw_ready_cyc", first_ready, 2);
        check("sw_start_cyc", first_start, 3);
        check("sw_busy_fall_gap", fall_gap, 1);

        // tx_busy is held high externally for 50 cycles before the first byte.
        @(negedge clk);
        ext_busy = 1'b1;
        if1.req_data[31:0] = 32'h0BADF00D;
        if1.req_valid = 2'b01;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | if1.tx_start;
            if (if1.req_ready[0]) if1.req_valid[0] = 1'b0;
        end
        check("hs_hold_no_start", seen, 0);
        check("hs_accepted", if1.req_valid, 0);
        ext_busy = 1'b0;
        wait_idle(300);
        check("hs_first_start", first_start, 1);
        check("hs_len", sent.size(), 5);
        check_word("hs_w", 0, 8'hA0, 32'h0BADF00D);

        // Reset while the second byte is inside the transmitter.
        @(negedge clk);
        if1.req_data[31:0] = 32'hCAFEF00D;
        if1.req_valid = 2'b01;
        nstart = 0;
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            if (if1.req_ready[0]) if1.req_valid[0] = 1'b0;
            if (if1.tx_start) nstart++;
            if (nstart == 2 && if1.tx_busy) hit = 1'b1;
        end
        check("rm_reached", hit, 1);
        rst = 1'b1;
        #1;
        check("rm_ready", if1.req_ready, 0);
        check("rm_start", if1.tx_start, 0);
        check("rm_busy", if1.busy, 0);
        check("rm_data", if1.tx_data, 0);
        check("rm_gid", if1.grant_id, 0);
        if1.req_data[31:0] = 32'h13579BDF;
        if1.req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("rm_inflight", if1.tx_busy, 1);
        rst = 1'b0;
        wait_idle(300);
        check("rm_low_late", first_low > 2, 1);
        check("rm_start_after_low", first_start, first_low + 1);
        check("rm_len", sent.size(), 5);
        check_word("rm_w", 0, 8'hA0, 32'h13579BDF);

        // Untagged 2-byte instance.
        begin
            logic [7:0] q2[$];
            int   cyc, rdy2, last_fall2, gap2, drops;
            logic done2, busy_at1, ptb, pb;
            cyc = 0; rdy2 = 0; last_fall2 = -1; gap2 = -1; drops = 0;
            done2 = 1'b0; busy_at1 = 1'b0;
            @(negedge clk);
            ptb = if2.tx_busy; pb = if2.busy;
            if2.req_data  = {16'h0000, 16'h1234};
            if2.req_valid = 2'b01;
            while (!done2 && cyc < 300) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) busy_at1 = if2.busy;
                if (if2.req_ready[0]) begin
                    rdy2++;
                    if2.req_valid[0] = 1'b0;
                end
                if (if2.tx_start) q2.push_back(if2.tx_data);
                if (ptb && !if2.tx_busy) last_fall2 = cyc;
                if (pb && !if2.busy) begin
                    drops++;
                    gap2 = cyc - last_fall2;
                end
                ptb = if2.tx_busy;
                pb  = if2.busy;
                if (cyc >= 2 && if2.req_valid == '0 && !if2.busy) done2 = 1'b1;
            end
            check("nt_idle_reached", done2, 1);
            check("nt_len", q2.size(), 2);
            check("nt_b0", (q2.size() > 0) ? q2[0] : 8'hxx, 8'h12);
            check("nt_b1", (q2.size() > 1) ? q2[1] : 8'hxx, 8'h34);
            check("nt_rdy", rdy2, 1);
            check("nt_busy_at_grant", busy_at1, 1);
            check("nt_busy_drops", drops, 1);
            check("nt_busy_fall_gap", gap2, 1);
        end

        @(negedge clk);
        check("start_rule", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
